// File: rtl/online_otf_convert_if.sv
// Handshake bundle between the online multiplier, the OTF converter and result capture.
// Optional early-sign outputs are present only when OTF_EARLY_SIGN_EN is defined.
interface online_otf_convert_if #(
  parameter int N = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [2*N-1:0]  z;
  logic            out_valid;
  logic            out_ready;
  logic [N:0]      q;
  logic            busy;
`ifdef OTF_EARLY_SIGN_EN
  logic            sign_valid;
  logic            sign_neg;
`endif

  modport master (
    output in_valid, z, out_ready,
    input  in_ready, out_valid, q, busy
`ifdef OTF_EARLY_SIGN_EN
    , input sign_valid, sign_neg
`endif
  );

  modport slave (
    input  in_valid, z, out_ready,
    output in_ready, out_valid, q, busy
`ifdef OTF_EARLY_SIGN_EN
    , output sign_valid, sign_neg
`endif
  );
endinterface

// File: rtl/online_otf_convert.sv
// On-the-fly conversion of an N-digit borrow-save word (MSD first) into an N+1 bit
// two's-complement fraction. Optional early sign report under OTF_EARLY_SIGN_EN.
module online_otf_convert #(
  parameter int N = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  online_otf_convert_if.slave  bus
);
  localparam int WL = 2 * N;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  state_e          state_q, state_d;
  logic [WL-1:0]   sr_q, sr_d;
  logic [N:0]      acc_q, acc_d;    // Q: value of digits consumed so far
  logic [N:0]      accm_q, accm_d;  // QM: Q minus one ulp of the current position
  logic [N:0]      res_q, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  logic            d_pos, d_neg;

  // Codes 00 and 11 both decode to zero.
  assign d_pos = sr_q[WL-1] & ~sr_q[WL-2];
  assign d_neg = sr_q[WL-2] & ~sr_q[WL-1];

`ifdef OTF_EARLY_SIGN_EN
  logic sign_valid_q, sign_valid_d;
  logic sign_neg_q, sign_neg_d;
`endif

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    acc_d       = acc_q;
    accm_d      = accm_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
`ifdef OTF_EARLY_SIGN_EN
    sign_valid_d = sign_valid_q;
    sign_neg_d   = sign_neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sr_d    = bus.z;
          acc_d   = '0;
          accm_d  = '1;
          cnt_d   = '0;
          state_d = CONV;
`ifdef OTF_EARLY_SIGN_EN
          sign_valid_d = 1'b0;
          sign_neg_d   = 1'b0;
`endif
        end
      end
      CONV: begin
        sr_d = {sr_q[WL-3:0], 2'b00};
        if (d_pos) begin
          acc_d  = {acc_q[N-1:0], 1'b1};
          accm_d = {acc_q[N-1:0], 1'b0};
        end else if (d_neg) begin
          acc_d  = {accm_q[N-1:0], 1'b1};
          accm_d = {accm_q[N-1:0], 1'b0};
        end else begin
          acc_d  = {acc_q[N-1:0], 1'b0};
          accm_d = {accm_q[N-1:0], 1'b1};
        end
`ifdef OTF_EARLY_SIGN_EN
        if (!sign_valid_q && (d_pos || d_neg)) begin
          sign_valid_d = 1'b1;
          sign_neg_d   = d_neg;
        end
`endif
        cnt_d = cnt_q + CW'(1);
        // Last digit: publish the freshly updated Q on the same edge.
        if (cnt_q == CW'(N - 1)) begin
          cnt_d       = '0;
          res_d       = acc_d;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      acc_q       <= '0;
      accm_q      <= '1;
      res_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      acc_q       <= acc_d;
      accm_q      <= accm_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef OTF_EARLY_SIGN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_valid_q <= 1'b0;
      sign_neg_q   <= 1'b0;
    end else begin
      sign_valid_q <= sign_valid_d;
      sign_neg_q   <= sign_neg_d;
    end
  end

  assign bus.sign_valid = sign_valid_q;
  assign bus.sign_neg   = sign_neg_q;
`endif

  // in_ready is gated by reset so nothing is accepted while rst_n is low.
  assign bus.in_ready  = (state_q == IDLE) & rst_n;
  assign bus.busy      = (state_q == CONV);
  assign bus.out_valid = out_valid_q;
  assign bus.q         = res_q;
endmodule

// File: tb/tb_online_otf_convert.sv
// Directed bench for online_otf_convert: vector table plus back-pressure and reset sequences.
module tb_online_otf_convert;
  localparam int N = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  online_otf_convert_if #(.N(N)) bus ();

  online_otf_convert #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] z;
    logic [8:0]  q;
    logic        sv;
    logic        sn;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Accepts one word and waits for out_valid, leaving the result pending in DONE.
  task automatic feed(input logic [15:0] zw, input logic [8:0] exp_q, input string tag);
    int lat;
    chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.z        = zw;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.z        = 16'hDEAD;
    chk({tag, " busy"}, 32'(bus.busy), 32'd1);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, " latency"}, 32'(lat), 32'd8);
    chk({tag, " q"}, 32'(bus.q), 32'(exp_q));
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, " out_valid_drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, " in_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [8:0] held;
    checks = 0;
    errors = 0;

    vecs[0] = '{16'h0000, 9'h000, 1'b0, 1'b0};
    vecs[1] = '{16'h8000, 9'h080, 1'b1, 1'b0};
    vecs[2] = '{16'h4000, 9'h180, 1'b1, 1'b1};
    vecs[3] = '{16'h9555, 9'h001, 1'b1, 1'b0};
    vecs[4] = '{16'hAAAA, 9'h0FF, 1'b1, 1'b0};
    vecs[5] = '{16'h5555, 9'h101, 1'b1, 1'b1};
    vecs[6] = '{16'hF000, 9'h000, 1'b0, 1'b0};
    vecs[7] = '{16'hF800, 9'h020, 1'b1, 1'b0};
    vecs[8] = '{16'h0001, 9'h1FF, 1'b1, 1'b1};
    vecs[9] = '{16'hFFFE, 9'h001, 1'b1, 1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.z         = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst q", 32'(bus.q), 32'd0);
`ifdef OTF_EARLY_SIGN_EN
    chk("rst sign_valid", 32'(bus.sign_valid), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      feed(vecs[i].z, vecs[i].q, $sformatf("vec%0d", i));
`ifdef OTF_EARLY_SIGN_EN
      chk($sformatf("vec%0d sign_valid", i), 32'(bus.sign_valid), 32'(vecs[i].sv));
      if (vecs[i].sv)
        chk($sformatf("vec%0d sign_neg", i), 32'(bus.sign_neg), 32'(vecs[i].sn));
`endif
      drain($sformatf("vec%0d", i));
    end

`ifdef OTF_EARLY_SIGN_EN
    // Sign must appear after the first CONV edge, then clear on the next acceptance.
    bus.in_valid = 1'b1;
    bus.z        = 16'h4000;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("early sign_valid", 32'(bus.sign_valid), 32'd1);
    chk("early sign_neg", 32'(bus.sign_neg), 32'd1);
    for (int i = 0; i < 7; i++) @(negedge clk);
    chk("early done", 32'(bus.out_valid), 32'd1);
    drain("early");
    bus.in_valid = 1'b1;
    bus.z        = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("sign clear on accept", 32'(bus.sign_valid), 32'd0);
    for (int i = 0; i < 8; i++) @(negedge clk);
    chk("zero word sign_valid", 32'(bus.sign_valid), 32'd0);
    drain("zero word");
`endif

    // Back-pressure: result must hold and new words must be ignored.
    feed(16'h9555, 9'h001, "bp");
    held = bus.q;
    bus.in_valid = 1'b1;
    bus.z        = 16'hAAAA;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp out_valid c%0d", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp q c%0d", i), 32'(bus.q), 32'h001);
      chk($sformatf("bp in_ready c%0d", i), 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    drain("bp");
    chk("bp q held after drain", 32'(bus.q), 32'(held));
    feed(16'hF800, 9'h020, "bp2");
    drain("bp2");

    // Reset during the fourth CONV digit aborts the word.
    bus.in_valid = 1'b1;
    bus.z        = 16'hAAAA;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre-abort busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort in_ready", 32'(bus.in_ready), 32'd0);
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort q", 32'(bus.q), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-abort in_ready", 32'(bus.in_ready), 32'd1);
    repeat (10) @(negedge clk);
    chk("post-abort no stale out_valid", 32'(bus.out_valid), 32'd0);
    feed(16'h5555, 9'h101, "post-abort");
    drain("post-abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
